// File: rtl/prach_fft_frame_seq.sv
// Cuts a bursty sample stream into 2^len FFT frames with sync/valid and one-cycle-early ahead controls.
// Latency: din -> dout_*_ahead 1 cycle, din -> dout_* 2 cycles; errors reported 1 cycle after the event.
// Backpressure: none; gaps in din_dv pass straight through as gaps in dout_dv, and the frame count holds.
module prach_fft_frame_seq #(
    parameter int NUM_FFT_LENGTH = 6,
    parameter bit CONTINUOUS     = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         cfg_len,
    input  logic               start,
    input  logic               abort,
    input  logic signed [17:0] din_dr,
    input  logic signed [17:0] din_di,
    input  logic               din_dv,
    output logic signed [17:0] dout_dr,
    output logic signed [17:0] dout_di,
    output logic               dout_dv,
    output logic               sync_out,
    output logic               dout_dv_ahead,
    output logic               sync_ahead_out,
    output logic               busy,
    output logic               frame_done,
    output logic               err_start,
    output logic               err_cfg
);
    localparam int CW = NUM_FFT_LENGTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} state_t;

    state_t          state, state_nxt;
    logic [3:0]      len_q, len_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt, cnt_inc, frame_size;
    logic            accept, first, last, cfg_bad;
    logic            err_start_nxt, err_cfg_nxt;

    logic               a_vld, a_sync, a_last;
    logic signed [17:0] a_dr, a_di;
    logic               b_vld, b_sync, b_last;
    logic signed [17:0] b_dr, b_di;

    assign cfg_bad    = (cfg_len == 4'd0) || (cfg_len > 4'(NUM_FFT_LENGTH));
    assign frame_size = CW'(1) << len_q;
    // Count including the sample being accepted this cycle; sample 0 always counts as 1.
    assign cnt_inc    = (state == S_RUN) ? cnt_q + CW'(1) : CW'(1);
    assign accept     = din_dv && !abort && (state != S_IDLE);
    assign first      = accept && (state == S_ARMED);
    assign last       = accept && (cnt_inc == frame_size);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            len_q     <= 4'(NUM_FFT_LENGTH);
            cnt_q     <= '0;
            err_start <= 1'b0;
            err_cfg   <= 1'b0;
        end else begin
            state     <= state_nxt;
            len_q     <= len_nxt;
            cnt_q     <= cnt_nxt;
            err_start <= err_start_nxt;
            err_cfg   <= err_cfg_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        len_nxt       = len_q;
        cnt_nxt       = cnt_q;
        err_start_nxt = 1'b0;
        err_cfg_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                // abort also suppresses a simultaneous start here, so abort always wins
                if (start && !abort) begin
                    state_nxt = S_ARMED;
                    cnt_nxt   = '0;
                    if (cfg_bad) begin
                        len_nxt     = 4'(NUM_FFT_LENGTH);
                        err_cfg_nxt = 1'b1;
                    end else begin
                        len_nxt = cfg_len;
                    end
                end
            end
            S_ARMED, S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    err_start_nxt = start;
                    if (last) begin
                        cnt_nxt   = '0;
                        state_nxt = CONTINUOUS ? S_ARMED : S_IDLE;
                    end else if (accept) begin
                        cnt_nxt   = cnt_inc;
                        state_nxt = S_RUN;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_vld  <= 1'b0;
            a_sync <= 1'b0;
            a_last <= 1'b0;
            a_dr   <= '0;
            a_di   <= '0;
        end else begin
            a_vld  <= accept;
            a_sync <= first;
            a_last <= last;
            if (accept) begin
                a_dr <= din_dr;
                a_di <= din_di;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_vld  <= 1'b0;
            b_sync <= 1'b0;
            b_last <= 1'b0;
            b_dr   <= '0;
            b_di   <= '0;
        end else begin
            b_vld  <= a_vld;
            b_sync <= a_sync;
            b_last <= a_last;
            if (a_vld) begin
                b_dr <= a_dr;
                b_di <= a_di;
            end
        end
    end

    assign dout_dv_ahead  = a_vld;
    assign sync_ahead_out = a_sync;
    assign dout_dv        = b_vld;
    assign sync_out       = b_sync;
    assign frame_done     = b_last;
    assign dout_dr        = b_dr;
    assign dout_di        = b_di;
    assign busy           = (state != S_IDLE);

endmodule

// File: doc/prach_fft_frame_seq.md
Name: prach_fft_frame_seq

Overview:
Frame sequencer in front of the radix-2 DIT FFT stage chain. It takes a continuous or bursty sample stream and cuts it into FFT frames of 2^len samples. It generates the sync/valid control pair and the one-cycle-early "ahead" control pair that the twiddler and butterfly stages consume. It also handles arming, abort, frame-done reporting and error flags, so the stage chain never sees a partial or misaligned frame start.

Parameters:
NUM_FFT_LENGTH, 6, maximum log2 frame length; the frame counter width is NUM_FFT_LENGTH+1.
CONTINUOUS, 0, 1 = re-arm automatically after each frame_done; 0 = return to IDLE and wait for start.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
cfg_len  input  4  log2 frame length, sampled only on the IDLE->ARMED transition
start  input  1  arm request pulse
abort  input  1  synchronous abort pulse
din_dr  input  18  sample real, signed
din_di  input  18  sample imag, signed
din_dv  input  1  sample valid
dout_dr  output  18  sample real, aligned with dout_dv
dout_di  output  18  sample imag, aligned with dout_dv
dout_dv  output  1  valid to FFT chain
sync_out  output  1  first sample of frame, aligned with dout_dv
dout_dv_ahead  output  1  dout_dv one cycle early
sync_ahead_out  output  1  sync_out one cycle early
busy  output  1  state != IDLE
frame_done  output  1  one-cycle pulse, coincident with the dout_dv of the last sample
err_start  output  1  one-cycle pulse: start received while ARMED or RUN
err_cfg  output  1  one-cycle pulse: cfg_len of 0 or > NUM_FFT_LENGTH was clamped

Behaviour:
- Reset: state=IDLE, counter=0. All outputs 0, including data.
- Reset can assert at any time, including mid-frame. The pipeline is flushed and no sync or frame_done is produced for the lost frame.
- States:
  - IDLE: on start, latch len and go to ARMED. If cfg_len==0 or cfg_len>NUM_FFT_LENGTH, latch len=NUM_FFT_LENGTH and pulse err_cfg.
  - ARMED: the first din_dv is accepted as frame sample 0, counter=1, go to RUN.
  - RUN: each din_dv is accepted and increments the counter. The sample that makes counter==2^len is the last sample. After it, go to ARMED if CONTINUOUS=1, else IDLE.
- din_dv in IDLE is dropped: no output valid is produced.
- Gaps (din_dv=0) inside RUN are allowed. Output valids carry the same gaps, and the counter holds.
- Pipeline, two register stages:
  - Stage A registers data, accept-valid and sync (sample 0). Stage A drives dout_dv_ahead and sync_ahead_out.
  - Stage B re-registers stage A. Stage B drives dout_dr, dout_di, dout_dv and sync_out.
- Latency: din -> dout_dv_ahead is 1 cycle; din -> dout_dv is 2 cycles. dout_dv_ahead(t) == dout_dv(t+1) always; the same holds for the sync pair.
- Data is passed unmodified; there is no arithmetic or width change. dout_dr/dout_di hold their last value when dout_dv=0.
- frame_done is registered through the same two stages as the last-sample flag.
- abort:
  - In ARMED or RUN, go to IDLE in the same cycle. The counter clears and input on that cycle is not accepted.
  - Samples already in stages A/B still emerge. frame_done is not asserted for the aborted frame.
  - abort in IDLE has no effect.
  - abort and start in the same cycle: abort wins, state=IDLE, no err_start.
- start while ARMED or RUN: ignored and err_start pulsed.
- start in the same cycle as the last sample with CONTINUOUS=0: it counts as a start in RUN, so it is ignored, err_start is pulsed, and the state ends in IDLE.
- CONTINUOUS=1: len stays latched across frames. cfg_len changes take effect only after returning to IDLE via abort.
- busy is combinational from state.

Test Plan:
- Basic frame: cfg_len=3, start, then 8 consecutive din_dv with data 0..7. Required: dout_dv high for 8 cycles starting 2 cycles after the first din_dv; sync_out with data 0; frame_done with data 7; busy low afterwards; a following din_dv produces no output.
- Ahead alignment: cfg_len=6 with random gaps in din_dv over 64 accepted samples. Required: each cycle, dout_dv_ahead(t) == dout_dv(t+1) and sync_ahead_out(t) == sync_out(t+1); exactly 64 output valids and one sync.
- Continuous: CONTINUOUS=1, cfg_len=2, one start, 12 valid samples. Required: 3 sync_out pulses on samples 0, 4 and 8; 3 frame_done pulses on samples 3, 7 and 11; busy stays high.
- Abort mid-frame: cfg_len=4, abort asserted after 5 accepted samples together with a start pulse. Required: 5 output valids, no frame_done, no err_start, state IDLE; a new start then produces a fresh sync.
- Errors: start during RUN -> one err_start pulse, frame unaffected. cfg_len=9 with NUM_FFT_LENGTH=6 -> err_cfg pulse and frame length 64.
- Async reset mid-frame: assert rst for 1 cycle mid-RUN. Required: all outputs 0 immediately, without waiting for a clock edge; busy=0; no frame_done.
